// File: rtl/fpu_issue.sv
// ---------------------------------------------------------------------------------------------
// fpu_issue: initiator side of the FPU instruction interface.
//
// Buffers FP instructions from the core in a small FIFO and drives the FPU's single
// instruction port with one instruction or bubble per cycle. The FIFO head is held while any
// of its source registers matches the destination of an instruction still inside the FPU
// pipeline. Results are captured from fpu_out_i at the fixed FPU latency and returned to the
// core tagged with their destination register.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   in_valid_i     core presents an instruction
//   in_ready_o     FIFO can accept (never while full)
//   in_insn_i      RISC-V FP instruction
//   fpu_insn_o     registered instruction (or bubble) to the FPU
//   fpu_out_i      FPU writeback data, FPU_LAT cycles after the instruction
//   res_valid_o    result beat, no backpressure
//   res_data_o     result value
//   res_rd_o       destination register of the result
//   res_illegal_o  result belongs to an unsupported opcode
//   busy_o         registered: FIFO non-empty or any instruction in flight
//   stall_cnt_o    saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------------------------

module fpu_issue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FPU_LAT     = 5,
    parameter logic [31:0] BUBBLE_INSN = 32'h0000_0053
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_insn_i,
    output logic [31:0] fpu_insn_o,
    input  logic [31:0] fpu_out_i,
    output logic        res_valid_o,
    output logic [31:0] res_data_o,
    output logic [4:0]  res_rd_o,
    output logic        res_illegal_o,
    output logic        busy_o,
    output logic [15:0] stall_cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StStall
    } state_e;

    state_e state_q, state_d;

    // Input FIFO
    logic [31:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            fifo_full, fifo_empty;
    logic            push, pop;

    // Set on the first clock edge that samples rst_ni high; keeps in_ready_o low until then.
    logic init_q;

    // Scoreboard, age 0 is the entry currently on fpu_insn_o
    logic [FPU_LAT:0]      sb_valid_q;
    logic [FPU_LAT:0][4:0] sb_rd_q;
    logic [FPU_LAT:0]      sb_ill_q;

    logic [31:0] fpu_insn_q, fpu_insn_d;
    logic        res_valid_q;
    logic [31:0] res_data_q;
    logic [4:0]  res_rd_q;
    logic        res_illegal_q;
    logic        busy_q;
    logic [15:0] stall_cnt_q;

    // Head decode
    logic [31:0] head;
    logic [4:0]  head_opc;
    logic [4:0]  head_rd, head_rs1, head_rs2, head_rs3;
    logic        head_r4, head_opfp, head_illegal;
    logic        use_rs12;

    logic [FPU_LAT-1:0] haz_vec;
    logic               hazard;
    logic               issue;
    logic               stall_inc;
    logic               more_after_pop;

    // -----------------------------------------------------------------------------------------
    // FIFO status and handshake
    // -----------------------------------------------------------------------------------------
    assign fifo_full  = (count_q == CntW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready_o = rst_ni && init_q && !fifo_full;
    assign push       = in_valid_i && in_ready_o;
    assign pop        = issue;

    assign count_d = count_q + CntW'(push) - CntW'(pop);

    // -----------------------------------------------------------------------------------------
    // Head decode: bits [6:2] select R4 (100xx) or OP-FP (101xx); anything else is illegal
    // and carries no sources.
    // -----------------------------------------------------------------------------------------
    assign head         = mem_q[rd_ptr_q];
    assign head_opc     = head[6:2];
    assign head_rd      = head[11:7];
    assign head_rs1     = head[19:15];
    assign head_rs2     = head[24:20];
    assign head_rs3     = head[31:27];
    assign head_r4      = (head_opc[4:2] == 3'b100);
    assign head_opfp    = (head_opc[4:2] == 3'b101);
    assign head_illegal = !(head_r4 || head_opfp);
    assign use_rs12     = head_r4 || head_opfp;

    // An entry with rd = 0 never matches, which also keeps source x0/f0 from hazarding.
    // The oldest entry (age FPU_LAT) is excluded: its data is on fpu_out_i this cycle.
    for (genvar g = 0; g < FPU_LAT; g++) begin : g_haz
        assign haz_vec[g] = sb_valid_q[g] && (sb_rd_q[g] != 5'd0) &&
                            ((use_rs12 && ((head_rs1 == sb_rd_q[g]) ||
                                           (head_rs2 == sb_rd_q[g]))) ||
                             (head_r4 && (head_rs3 == sb_rd_q[g])));
    end

    assign hazard = |haz_vec;

    // Whether the FIFO still holds something after popping the head this cycle.
    assign more_after_pop = (count_q > CntW'(1)) || push;

    // -----------------------------------------------------------------------------------------
    // Issue FSM
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        stall_inc = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (push || !fifo_empty) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (fifo_empty) begin
                    state_d = push ? StIssue : StIdle;
                end else if (hazard) begin
                    // The detection cycle already holds the head, so it counts as a stall.
                    state_d   = StStall;
                    stall_inc = 1'b1;
                end else begin
                    issue   = 1'b1;
                    state_d = more_after_pop ? StIssue : StIdle;
                end
            end
            StStall: begin
                if (fifo_empty) begin
                    state_d = push ? StIssue : StIdle;
                end else if (hazard) begin
                    stall_inc = 1'b1;
                end else begin
                    // Hazard has cleared: the head goes out this very cycle.
                    issue   = 1'b1;
                    state_d = more_after_pop ? StIssue : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign fpu_insn_d = issue ? head : BUBBLE_INSN;

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            init_q        <= 1'b0;
            fpu_insn_q    <= BUBBLE_INSN;
            sb_valid_q    <= '0;
            sb_rd_q       <= '0;
            sb_ill_q      <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_illegal_q <= 1'b0;
            busy_q        <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            init_q     <= 1'b1;
            fpu_insn_q <= fpu_insn_d;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end

            // Bubbles enter the scoreboard as invalid entries.
            sb_valid_q <= {sb_valid_q[FPU_LAT-1:0], issue};
            sb_rd_q    <= {sb_rd_q[FPU_LAT-1:0], head_rd};
            sb_ill_q   <= {sb_ill_q[FPU_LAT-1:0], head_illegal};

            res_valid_q <= sb_valid_q[FPU_LAT];
            if (sb_valid_q[FPU_LAT]) begin
                res_data_q    <= fpu_out_i;
                res_rd_q      <= sb_rd_q[FPU_LAT];
                res_illegal_q <= sb_ill_q[FPU_LAT];
            end

            busy_q <= !fifo_empty || (|sb_valid_q);

            if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_insn_i;
        end
    end

    assign fpu_insn_o    = fpu_insn_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_rd_o      = res_rd_q;
    assign res_illegal_o = res_illegal_q;
    assign busy_o        = busy_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_fpu_issue.sv
// ---------------------------------------------------------------------------------------------
// tb_fpu_issue: directed self-checking bench for fpu_issue with a small behavioural FPU stub
// (5-cycle pipeline, FADD.S / FMUL.S on normal numbers, f0 reserved at 2.0).
// ---------------------------------------------------------------------------------------------

module tb_fpu_issue;

    localparam int          LAT    = 5;
    localparam logic [31:0] BUBBLE = 32'h0000_0053;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] fpu_insn;
    logic [31:0] fpu_out;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_illegal;
    logic        busy;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_issue #(
        .DEPTH      (4),
        .FPU_LAT    (LAT),
        .BUBBLE_INSN(BUBBLE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_insn_i    (in_insn),
        .fpu_insn_o   (fpu_insn),
        .fpu_out_i    (fpu_out),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_rd_o     (res_rd),
        .res_illegal_o(res_illegal),
        .busy_o       (busy),
        .stall_cnt_o  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------------------------
    // FPU stub
    // ------------------------------------------------------------------------------------------
    logic [31:0] freg      [32];
    logic [31:0] pipe_data [LAT+1];
    logic [4:0]  pipe_rd   [LAT+1];
    logic        pipe_wr   [LAT+1];

    function automatic real s2r(input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        e = {3'b000, b[30:23]} + 11'd896;
        if (b[30:0] == 31'd0) d = {b[31], 63'd0};
        else d = {b[31], e, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_model(input logic [31:0] insn);
        real a;
        real b;
        a = s2r(freg[insn[19:15]]);
        b = s2r(freg[insn[24:20]]);
        if (insn[6:2] == 5'b10100) begin
            if (insn[31:27] == 5'b00000) return r2s(a + b);
            if (insn[31:27] == 5'b00010) return r2s(a * b);
            return 32'h0;
        end
        if (insn[6:4] == 3'b100) return 32'h0;
        return 32'h7FC0_0000;
    endfunction

    always @(posedge clk) begin
        pipe_data[1] <= fpu_model(fpu_insn);
        pipe_rd[1]   <= fpu_insn[11:7];
        pipe_wr[1]   <= (fpu_insn[6:5] == 2'b10);
        for (int k = 2; k <= LAT; k++) begin
            pipe_data[k] <= pipe_data[k-1];
            pipe_rd[k]   <= pipe_rd[k-1];
            pipe_wr[k]   <= pipe_wr[k-1];
        end
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) freg[k] <= (k == 0) ? 32'h4000_0000 : 32'h0;
        end else if (pipe_wr[LAT] && (pipe_rd[LAT] != 5'd0)) begin
            freg[pipe_rd[LAT]] <= pipe_data[LAT];
        end
    end

    assign fpu_out = pipe_data[LAT];

    // ------------------------------------------------------------------------------------------
    // Passive monitor: records issued instructions and result tags
    // ------------------------------------------------------------------------------------------
    logic        mon_en = 1'b0;
    logic [31:0] issued [$];
    logic [4:0]  res_rds [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (fpu_insn !== BUBBLE) issued.push_back(fpu_insn);
            if (res_valid === 1'b1) res_rds.push_back(res_rd);
        end
    end

    // ------------------------------------------------------------------------------------------
    // Helpers (stimulus only)
    // ------------------------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_insn  = 32'h0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------------------------
    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_insn  = 32'h0;
        step();
        step();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        n_cmp++;
        if (fpu_insn !== BUBBLE) begin
            n_bad++; $display("FAIL reset_fpu_insn: got %h want %h", fpu_insn, BUBBLE);
        end
        n_cmp++;
        if ({res_valid, res_data, res_rd, res_illegal, busy, stall_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v%b d%h rd%0d il%b busy%b sc%0d want all 0",
                     res_valid, res_data, res_rd, res_illegal, busy, stall_cnt);
        end
        rst_n = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL release_cycle_in_ready: got %b want 0", in_ready);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (fpu_insn !== BUBBLE) begin
                n_bad++; $display("FAIL idle_fpu_insn[%0d]: got %h want %h", i, fpu_insn, BUBBLE);
            end
            n_cmp++;
            if (res_valid !== 1'b0) begin
                n_bad++; $display("FAIL idle_res_valid[%0d]: got %b want 0", i, res_valid);
            end
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++; $display("FAIL idle_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++; $display("FAIL idle_busy[%0d]: got %b want 0", i, busy);
            end
            step();
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1;
        in_insn  = 32'h0000_00D3;
        step();
        in_valid = 1'b0;
        // No bypass: the FIFO holds the instruction for one cycle first.
        n_cmp++;
        if (fpu_insn !== BUBBLE) begin
            n_bad++; $display("FAIL single_no_bypass: got %h want %h", fpu_insn, BUBBLE);
        end
        step();
        n_cmp++;
        if (fpu_insn !== 32'h0000_00D3) begin
            n_bad++; $display("FAIL single_issue: got %h want 000000d3", fpu_insn);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++; $display("FAIL single_busy_inflight: got %b want 1", busy);
                end
            end
            n_cmp++;
            if (res_valid !== 1'b0) begin
                n_bad++; $display("FAIL single_early_res[N+%0d]: got %b want 0", k, res_valid);
            end
        end
        step();
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 32'h4080_0000 || res_rd !== 5'd1 ||
            res_illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL single_result: got v%b d%h rd%0d il%b want v1 d40800000 rd1 il0",
                     res_valid, res_data, res_rd, res_illegal);
        end
        step();
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_res_once: got %b want 0", res_valid);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL single_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_dependent();
        do_reset();
        in_valid = 1'b1;
        in_insn  = 32'h0000_00D3;
        step();
        in_insn = 32'h1010_8153;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL dep_second_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (fpu_insn !== 32'h0000_00D3) begin
            n_bad++; $display("FAIL dep_producer_issue: got %h want 000000d3", fpu_insn);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++;
            if (fpu_insn !== BUBBLE) begin
                n_bad++; $display("FAIL dep_hold[N+%0d]: got %h want %h", k, fpu_insn, BUBBLE);
            end
        end
        step();
        n_cmp++;
        if (fpu_insn !== 32'h1010_8153) begin
            n_bad++; $display("FAIL dep_consumer_issue: got %h want 10108153", fpu_insn);
        end
        n_cmp++;
        if (res_valid !== 1'b1 || res_rd !== 5'd1 || res_data !== 32'h4080_0000) begin
            n_bad++;
            $display("FAIL dep_producer_result: got v%b rd%0d d%h want v1 rd1 d40800000",
                     res_valid, res_rd, res_data);
        end
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_bad++; $display("FAIL dep_stall_cnt: got %0d want 5", stall_cnt);
        end
        for (int k = 7; k <= 11; k++) begin
            step();
            n_cmp++;
            if (res_valid !== 1'b0) begin
                n_bad++; $display("FAIL dep_gap[N+%0d]: got %b want 0", k, res_valid);
            end
        end
        step();
        n_cmp++;
        if (res_valid !== 1'b1 || res_rd !== 5'd2 || res_data !== 32'h4180_0000) begin
            n_bad++;
            $display("FAIL dep_consumer_result: got v%b rd%0d d%h want v1 rd2 d41800000",
                     res_valid, res_rd, res_data);
        end
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_bad++; $display("FAIL dep_stall_cnt_final: got %0d want 5", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ilist [3];
        logic [4:0]  rlist [3];
        logic [31:0] exp_insn;
        logic        exp_rv;
        ilist = '{32'h0000_00D3, 32'h0000_0153, 32'h0000_0253};
        rlist = '{5'd1, 5'd2, 5'd4};
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            in_valid = (c < 3);
            in_insn  = (c < 3) ? ilist[c] : 32'h0;
            exp_insn = (c >= 2 && c <= 4) ? ilist[c-2] : BUBBLE;
            exp_rv   = (c >= 8 && c <= 10);
            n_cmp++;
            if (fpu_insn !== exp_insn) begin
                n_bad++; $display("FAIL b2b_fpu_insn[P+%0d]: got %h want %h", c, fpu_insn, exp_insn);
            end
            n_cmp++;
            if (res_valid !== exp_rv) begin
                n_bad++; $display("FAIL b2b_res_valid[P+%0d]: got %b want %b", c, res_valid, exp_rv);
            end
            if (exp_rv) begin
                n_cmp++;
                if (res_rd !== rlist[c-8] || res_data !== 32'h4080_0000) begin
                    n_bad++;
                    $display("FAIL b2b_result[P+%0d]: got rd%0d d%h want rd%0d d40800000",
                             c, res_rd, res_data, rlist[c-8]);
                end
            end
            step();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_bad++; $display("FAIL b2b_stall_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] blist [6];
        int          idx;
        int          guard;
        int          low_cycles;
        int          ibase;
        int          rbase;
        logic        acc;
        blist = '{32'h0000_00D3, 32'h1010_8153, 32'h0000_01D3,
                  32'h0000_0253, 32'h0000_02D3, 32'h0000_0353};
        do_reset();
        ibase      = issued.size();
        rbase      = res_rds.size();
        mon_en     = 1'b1;
        idx        = 0;
        guard      = 0;
        low_cycles = 0;
        while (idx < 6 && guard < 40) begin
            in_valid = 1'b1;
            in_insn  = blist[idx];
            acc      = in_ready;
            if (!in_ready) low_cycles++;
            step();
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (idx != 6) begin
            n_bad++; $display("FAIL bp_all_accepted: got %0d want 6", idx);
        end
        n_cmp++;
        if (low_cycles != 3) begin
            n_bad++; $display("FAIL bp_ready_low_cycles: got %0d want 3", low_cycles);
        end
        for (int k = 0; k < 25; k++) step();
        mon_en = 1'b0;
        n_cmp++;
        if (issued.size() - ibase != 6) begin
            n_bad++; $display("FAIL bp_issue_count: got %0d want 6", issued.size() - ibase);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (issued[ibase+i] !== blist[i]) begin
                    n_bad++;
                    $display("FAIL bp_issue_order[%0d]: got %h want %h", i, issued[ibase+i], blist[i]);
                end
            end
        end
        n_cmp++;
        if (res_rds.size() - rbase != 6) begin
            n_bad++; $display("FAIL bp_result_count: got %0d want 6", res_rds.size() - rbase);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (res_rds[rbase+i] !== 5'(i + 1)) begin
                    n_bad++;
                    $display("FAIL bp_result_order[%0d]: got rd%0d want rd%0d", i,
                             res_rds[rbase+i], i + 1);
                end
            end
        end
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_bad++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        in_valid = 1'b1;
        in_insn  = 32'h0000_0013;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (fpu_insn !== 32'h0000_0013) begin
            n_bad++; $display("FAIL illegal_issue: got %h want 00000013", fpu_insn);
        end
        for (int k = 1; k <= 6; k++) step();
        n_cmp++;
        if (res_valid !== 1'b1 || res_illegal !== 1'b1 || res_data !== 32'h7FC0_0000 ||
            res_rd !== 5'd0) begin
            n_bad++;
            $display("FAIL illegal_result: got v%b il%b d%h rd%0d want v1 il1 d7fc00000 rd0",
                     res_valid, res_illegal, res_data, res_rd);
        end
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_bad++; $display("FAIL illegal_stall_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int ibase;
        int rbase;
        do_reset();
        mon_en   = 1'b1;
        in_valid = 1'b1;
        in_insn  = 32'h0000_00D3;
        step();
        in_insn = 32'h1010_8153;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (fpu_insn !== 32'h0000_00D3) begin
            n_bad++; $display("FAIL rmid_issue: got %h want 000000d3", fpu_insn);
        end
        step();
        step();
        n_cmp++;
        if (stall_cnt !== 16'd2) begin
            n_bad++; $display("FAIL rmid_stall_before: got %0d want 2", stall_cnt);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ibase = issued.size();
        rbase = res_rds.size();
        n_cmp++;
        if (fpu_insn !== BUBBLE || stall_cnt !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_after_reset: got insn%h sc%0d busy%b rdy%b want %h 0 0 0",
                     fpu_insn, stall_cnt, busy, in_ready, BUBBLE);
        end
        for (int k = 0; k < 20; k++) step();
        mon_en = 1'b0;
        n_cmp++;
        if (res_rds.size() != rbase) begin
            n_bad++; $display("FAIL rmid_no_result: got %0d want 0", res_rds.size() - rbase);
        end
        n_cmp++;
        if (issued.size() != ibase) begin
            n_bad++; $display("FAIL rmid_fifo_flushed: got %0d issues want 0", issued.size() - ibase);
        end
        n_cmp++;
        if (stall_cnt !== 16'd0 || fpu_insn !== BUBBLE) begin
            n_bad++;
            $display("FAIL rmid_quiet: got sc%0d insn%h want 0 %h", stall_cnt, fpu_insn, BUBBLE);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_insn  = 32'h0;
        test_reset();
        test_single();
        test_dependent();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- Initiator side of the FPU instruction interface.
- Accepts FP instructions from the core over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FPU's single instruction port, one instruction or bubble per cycle. It checks each FIFO head for RAW hazards against in-flight instructions and holds the head until it is safe.
- Captures each result from `fpu_out` at its fixed latency and returns it to the core tagged with its destination register.

Parameters:
- DEPTH, 4, input FIFO entries (power of 2, ≥2).
- FPU_LAT, 5, cycles from an instruction appearing on `fpu_insn` to its result appearing on `fpu_out`.
- BUBBLE_INSN, 32'h0000_0053, idle encoding (FADD f0,f0,f0; f0 is FPU-reserved).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  core presents instruction
- in_ready  out  1  FIFO can accept
- in_insn  in  32  RISC-V FP instruction
- fpu_insn  out  32  registered instruction to FPU
- fpu_out  in  32  FPU writeback data
- res_valid  out  1  result beat (no backpressure)
- res_data  out  32  result value
- res_rd  out  5  destination register of result
- res_illegal  out  1  result belongs to unsupported opcode
- busy  out  1  FIFO non-empty or any instruction in flight
- stall_cnt  out  16  saturating count of hazard-stall cycles

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-low (rst_n sampled on posedge clk).
- Reset values:
  - FIFO emptied; scoreboard and result tags cleared.
  - `fpu_insn` = BUBBLE_INSN.
  - `in_ready` = 0 while `rst_n` is low, and 1 from the first cycle after release.
  - `res_valid`, `res_data`, `res_rd`, `res_illegal`, `busy`, `stall_cnt` all 0.
- Reset mid-operation: results of instructions already inside the FPU are never reported (no `res_valid`).
- Handshake and FIFO:
  - Push when `in_valid` && `in_ready`.
  - `in_ready` = !full; a push is never accepted when full, even if a pop occurs in the same cycle.
  - Push into an empty FIFO gives no bypass: the earliest issue is the next cycle.
  - Pointers wrap modulo DEPTH.
- Decode of the FIFO head (bits [6:2]):
  - 100xx = R4 type; sources rs1 [19:15], rs2 [24:20], rs3 [31:27].
  - 101xx = OP-FP; sources rs1 and rs2.
  - Any other value = illegal: no sources, issued anyway (FPU returns 32'h7FC00000), result tagged illegal.
- Scoreboard:
  - Shift register of FPU_LAT+1 entries {valid, rd, illegal}. Age 0 is the entry currently on `fpu_insn`; it shifts every cycle.
  - Bubbles enter as valid = 0.
  - rd = 0 never marks a hazard; source reg 0 never hazards.
- Hazard: the head's source matches the rd of any valid entry of age 0..FPU_LAT-1. A dependent instruction therefore reaches `fpu_insn` at least FPU_LAT+1 cycles after its producer.
- FSM (evaluated every cycle):
  - IDLE: FIFO empty → load BUBBLE_INSN. On a push, go to ISSUE next cycle.
  - ISSUE: head hazard-free → load head into `fpu_insn`, pop, push scoreboard entry. Stay in ISSUE if FIFO still non-empty, else go to IDLE. Head hazarded → go to STALL.
  - STALL: load BUBBLE_INSN, `stall_cnt` += 1 (saturates at 16'hFFFF). Return to ISSUE on the cycle the hazard clears; the head issues that cycle.
- Result return:
  - The scoreboard entry at age FPU_LAT is valid in the cycle `fpu_out` carries its data.
  - `res_*` are registered from that entry and `fpu_out` one cycle later, so an instruction on `fpu_insn` in cycle N returns `res_valid` in cycle N+FPU_LAT+1.
  - Results are in order, one per cycle maximum.
- `busy` is registered: (FIFO non-empty) OR (any scoreboard valid).

Test Plan:
- Reset release, idle 10 cycles → `fpu_insn` = 32'h00000053 constant; `res_valid` = 0; `in_ready` = 1; `busy` = 0.
- Push 32'h000000D3 (FADD f1,f0,f0), f0 = 32'h40000000 → `fpu_insn` = 32'h000000D3 in cycle N; `res_valid` in cycle N+6 with `res_data` = 32'h40800000, `res_rd` = 1.
- Push 32'h000000D3 then 32'h10108153 (FMUL f2,f1,f1) back-to-back → FMUL on `fpu_insn` at N+6; `stall_cnt` = 5; `res_data` = 32'h41800000, `res_rd` = 2 at cycle N+12.
- Three independent FADDs writing f1, f2, f4 from f0 → issue in consecutive cycles; results in consecutive cycles, in order, `stall_cnt` = 0.
- Dependent pair pushed, then hold `in_valid` = 1 with 4 more instructions → `in_ready` drops once 4 entries held; no instruction lost or duplicated.
- Push 32'h00000013 (non-FP opcode) → issued; `res_illegal` = 1, `res_data` = 32'h7FC00000.
- Assert `rst_n` = 0 for 1 cycle two cycles after an issue → no `res_valid` ever for that instruction; `stall_cnt` = 0; `fpu_insn` = BUBBLE_INSN.
